merge2_reader: RTL and testbench

//  Read-side consumer for a pair of sorted sync FIFOs in the merge-sort datapath.

---
 rtl/merge_pkg.sv | 12 +
 rtl/merge2_sel.sv | 19 +
 rtl/merge2_reader.sv | 107 ++++++++++
 tb/tb_merge2_reader.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/merge_pkg.sv
// Shared FSM encoding for the two-way run merger (merge2_reader).
package merge_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MERGE   = 3'd1,
        DRAIN_A = 3'd2,
        DRAIN_B = 3'd3,
        DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/merge2_sel.sv
// Head compare/select for merge2_reader; MERGE_DESCEND_EN selects descending order.
// Ties always favour A so equal keys keep their A-before-B order.
module merge2_sel #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] a_head,
    input  logic [DATA_WIDTH-1:0] b_head,
    output logic                  take_a
);

    always_comb begin
`ifdef MERGE_DESCEND_EN
        take_a = (a_head >= b_head);
`else
        take_a = (a_head <= b_head);
`endif
    end

endmodule

// File: rtl/merge2_reader.sv
// Merges one RUN_LEN run from each of two sorted FIFOs into a 2*RUN_LEN run.
// Sort direction is set in merge2_sel via MERGE_DESCEND_EN (default ascending).
module merge2_reader
    import merge_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LOG2_RUN   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] a_head,
    input  logic                  a_empty,
    output logic                  a_rd_en,
    input  logic [DATA_WIDTH-1:0] b_head,
    input  logic                  b_empty,
    output logic                  b_rd_en,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_wr_en,
    input  logic                  out_full,
    output logic                  run_done,
    output logic                  busy
);

    localparam int CNT_W = LOG2_RUN + 1;
    localparam logic [CNT_W-1:0] RUN_LEN = CNT_W'(1 << LOG2_RUN);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt_a, cnt_b;
    logic [CNT_W-1:0] cnt_a_inc, cnt_b_inc;
    logic             take_a;

    merge2_sel #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_sel (
        .a_head(a_head),
        .b_head(b_head),
        .take_a(take_a)
    );

    assign cnt_a_inc = cnt_a + 1'b1;
    assign cnt_b_inc = cnt_b + 1'b1;
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt = state;
        a_rd_en   = 1'b0;
        b_rd_en   = 1'b0;
        case (state)
            IDLE: begin
                if (en) state_nxt = MERGE;
            end
            MERGE: begin
                if (!out_full && !a_empty && !b_empty) begin
                    if (take_a) begin
                        a_rd_en = 1'b1;
                        if (cnt_a_inc == RUN_LEN) state_nxt = DRAIN_B;
                    end else begin
                        b_rd_en = 1'b1;
                        if (cnt_b_inc == RUN_LEN) state_nxt = DRAIN_A;
                    end
                end
            end
            DRAIN_A: begin
                if (!a_empty && !out_full) begin
                    a_rd_en = 1'b1;
                    if (cnt_a_inc == RUN_LEN) state_nxt = DONE;
                end
            end
            DRAIN_B: begin
                if (!b_empty && !out_full) begin
                    b_rd_en = 1'b1;
                    if (cnt_b_inc == RUN_LEN) state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = en ? MERGE : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt_a     <= '0;
            cnt_b     <= '0;
            out_data  <= '0;
            out_wr_en <= 1'b0;
            run_done  <= 1'b0;
        end else begin
            state     <= state_nxt;
            out_wr_en <= a_rd_en | b_rd_en;
            run_done  <= (state == DONE);
            if (a_rd_en) out_data <= a_head;
            else if (b_rd_en) out_data <= b_head;
            if (state == DONE) begin
                cnt_a <= '0;
                cnt_b <= '0;
            end else begin
                if (a_rd_en) cnt_a <= cnt_a_inc;
                if (b_rd_en) cnt_b <= cnt_b_inc;
            end
        end
    end

endmodule

// File: tb/tb_merge2_reader.sv
// Randomized self-checking bench for merge2_reader (RUN_LEN=2); honours MERGE_DESCEND_EN.
module tb_merge2_reader;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset, en;
    logic [DW-1:0] a_head, b_head, out_data;
    logic          a_empty, b_empty, a_rd_en, b_rd_en;
    logic          out_wr_en, out_full, run_done, busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [DW-1:0] qa[$], qb[$], exp_q[$];
    int pop_cyc[$], out_cyc[$], done_cyc[$];
    int stall_pct = 0, full_pct = 0;
    bit hold_b = 0, hold_full = 0, mon_en = 0;
    bit seen_pop = 0, first_a = 0;

    always #5 clk = ~clk;

    merge2_reader #(
        .DATA_WIDTH(DW),
        .LOG2_RUN(1)
    ) dut (
        .clk(clk), .reset(reset), .en(en),
        .a_head(a_head), .a_empty(a_empty), .a_rd_en(a_rd_en),
        .b_head(b_head), .b_empty(b_empty), .b_rd_en(b_rd_en),
        .out_data(out_data), .out_wr_en(out_wr_en), .out_full(out_full),
        .run_done(run_done), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Expected output of a run is just the sorted union of both input runs.
    task automatic load4(input logic [DW-1:0] a0, a1, b0, b1);
        logic [DW-1:0] ta[$], tb[$], te[$];
        ta = '{a0, a1};
        tb = '{b0, b1};
        te = '{a0, a1, b0, b1};
`ifdef MERGE_DESCEND_EN
        ta.rsort(); tb.rsort(); te.rsort();
`else
        ta.sort(); tb.sort(); te.sort();
`endif
        foreach (ta[i]) qa.push_back(ta[i]);
        foreach (tb[i]) qb.push_back(tb[i]);
        foreach (te[i]) exp_q.push_back(te[i]);
    endtask

    task automatic cycle();
        logic pa, pb, legal;
        logic [DW-1:0] e;
        a_empty  = (qa.size() == 0) || ($urandom_range(99) < stall_pct);
        b_empty  = (qb.size() == 0) || hold_b || ($urandom_range(99) < stall_pct);
        a_head   = (qa.size() != 0) ? qa[0] : $urandom;
        b_head   = (qb.size() != 0) ? qb[0] : $urandom;
        out_full = hold_full || ($urandom_range(99) < full_pct);
        @(negedge clk);
        if (mon_en) begin
            if (a_rd_en || b_rd_en) begin
                legal = !(a_rd_en && b_rd_en) && !(a_rd_en && a_empty) &&
                        !(b_rd_en && b_empty) && !out_full;
                check("rd_legal", {31'd0, legal}, 32'd1);
                if (!seen_pop) begin
                    seen_pop = 1;
                    first_a  = a_rd_en;
                end
                pop_cyc.push_back(cyc);
            end
            if (out_wr_en) begin
                out_cyc.push_back(cyc);
                e = (exp_q.size() != 0) ? exp_q.pop_front() : ~out_data;
                check("out_data", out_data, e);
                if (pop_cyc.size() != 0) check("latency", cyc, pop_cyc.pop_front() + 1);
                else check("latency", cyc, 32'hFFFF_FFFF);
            end
            if (run_done) done_cyc.push_back(cyc);
        end
        pa = a_rd_en;
        pb = b_rd_en;
        @(posedge clk);
        #1;
        if (pa && qa.size() != 0) void'(qa.pop_front());
        if (pb && qb.size() != 0) void'(qb.pop_front());
        cyc++;
    endtask

    task automatic run_until(input int want, input int maxc);
        int n = 0;
        while ((exp_q.size() != 0 || done_cyc.size() < want) && n < maxc) begin
            cycle();
            n++;
        end
        check("drained", exp_q.size(), 0);
        check("runs", done_cyc.size(), want);
    endtask

    task automatic clear_logs();
        out_cyc.delete();
        done_cyc.delete();
        seen_pop = 0;
    endtask

    initial begin
        int n, np;
        reset = 1'b1; en = 1'b0;
        repeat (2) cycle();
        reset = 1'b0;
        check("rst_wr_en", {31'd0, out_wr_en}, 0);
        check("rst_data", out_data, 0);
        check("rst_done", {31'd0, run_done}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        mon_en = 1;

        // basic merge, back-to-back outputs, run_done one cycle after last
        en = 1'b1;
        clear_logs();
        load4(1, 4, 2, 3);
        run_until(1, 40);
        check("n_out", out_cyc.size(), 4);
        if (out_cyc.size() == 4 && done_cyc.size() == 1) begin
            for (int i = 1; i < 4; i++) check("consec", out_cyc[i], out_cyc[i-1] + 1);
            check("done_lat", done_cyc[0], out_cyc[3] + 1);
        end

        // tie: A wins
        clear_logs();
        load4(5, 7, 5, 6);
        run_until(1, 40);
        check("tie_first_a", {31'd0, first_a}, 1);

        // B held empty for 3 cycles
        clear_logs();
        hold_b = 1;
        load4(1, 4, 2, 3);
        np = pop_cyc.size();
        repeat (3) cycle();
        check("bstall_pops", pop_cyc.size() - np, 0);
        check("bstall_outs", out_cyc.size(), 0);
        hold_b = 0;
        run_until(1, 40);

        // downstream full for 2 cycles mid-run
        clear_logs();
        load4(10, 20, 15, 25);
        repeat (3) cycle();
        hold_full = 1;
        np = out_cyc.size() + pop_cyc.size();
        cycle();
        n = pop_cyc.size();
        cycle();
        check("full_pops", pop_cyc.size() - n, 0);
        check("full_wr", {31'd0, out_wr_en}, 0);
        hold_full = 0;
        run_until(1, 40);

        // descending example data (ascending build gives 2,3,8,9)
        clear_logs();
        load4(9, 2, 8, 3);
        run_until(1, 40);

        // reset after two outputs
        clear_logs();
        load4(1, 4, 2, 3);
        n = 0;
        while (out_cyc.size() < 2 && n < 30) begin cycle(); n++; end
        check("pre_rst_outs", out_cyc.size(), 2);
        mon_en = 0;
        reset = 1'b1;
        cycle();
        reset = 1'b0; en = 1'b0;
        qa.delete(); qb.delete(); exp_q.delete(); pop_cyc.delete();
        check("mid_rst_wr", {31'd0, out_wr_en}, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_done", {31'd0, run_done}, 0);
        cycle();
        check("mid_rst_busy", {31'd0, busy}, 0);
        mon_en = 1; en = 1'b1;
        clear_logs();
        load4(3, 8, 1, 9);
        run_until(1, 40);

        // randomized runs with upstream stalls and downstream backpressure
        clear_logs();
        stall_pct = 25; full_pct = 20;
        for (int r = 0; r < 20; r++)
            load4($urandom_range(0, 15), $urandom_range(0, 15),
                  $urandom_range(0, 15), $urandom_range(0, 15));
        run_until(20, 3000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
